// File: rtl/adder6_pkg.sv
// adder6_pkg: shared types, chunk width and round-robin pick helper for the chunked adder scheduler
package adder6_pkg;
    localparam int CHUNK_W = 6;
    localparam int MAXREQ = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;
    // First valid index searching upward from last+1 with wrap over nreq requesters.
    function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid, input logic [2:0] last, input int nreq);
        rr_pick_t r;
        int j;
        r = '0;
        for (int k = 1; k <= MAXREQ; k++) begin
            j = (int'(last) + k) % nreq;
            if (k <= nreq && !r.found && valid[3'(j)]) begin
                r.found = 1'b1;
                r.idx = 3'(j);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/adder6_core.sv
// adder6_core: shared combinational 6-bit adder
// Ports: a, b (6-bit operands), cin (carry in) -> sum (6-bit), cout (carry out)
module adder6_core
    import adder6_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);
    assign {cout, sum} = (CHUNK_W+1)'(a) + (CHUNK_W+1)'(b) + (CHUNK_W+1)'(cin);
endmodule

// File: rtl/adder6_chunk_sched.sv
// adder6_chunk_sched: round-robin scheduler running wide additions one 6-bit chunk per cycle on one shared adder
// Ports: clk, rst (sync active-high); req_valid/req_ready/req_a/req_b/req_cin per requester (packed i*W);
//        rsp_valid/rsp_ready handshake with rsp_id, rsp_sum, rsp_cout held stable while valid
module adder6_chunk_sched
    import adder6_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CHUNKS = 4,
    parameter int IDW = $clog2(NREQ),
    localparam int W = CHUNK_W * CHUNKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout
);
    sched_state_t state_q, state_d;
    logic [IDW-1:0] last_q, last_d, id_q, id_d, sel;
    logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic carry_q, carry_d, cout_q, cout_d;
    logic [2:0] idx_q, idx_d;
    logic [CHUNK_W-1:0] ca, cb, cs;
    logic cc;
    rr_pick_t pick;

    assign pick = rr_pick(MAXREQ'(req_valid), 3'(last_q), NREQ);
    assign sel = IDW'(pick.idx);
    // Grant only in IDLE and never while reset is held.
    assign req_ready = (!rst && state_q == IDLE && pick.found) ? NREQ'(1) << sel : '0;

    assign ca = a_q[idx_q*CHUNK_W +: CHUNK_W];
    assign cb = b_q[idx_q*CHUNK_W +: CHUNK_W];

    adder6_core u_core (
        .a    (ca),
        .b    (cb),
        .cin  (carry_q),
        .sum  (cs),
        .cout (cc)
    );

    always_comb begin
        state_d = state_q;
        last_d = last_q;
        id_d = id_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        carry_d = carry_q;
        cout_d = cout_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: if (|req_ready) begin
                a_d = req_a[sel*W +: W];
                b_d = req_b[sel*W +: W];
                carry_d = req_cin[sel];
                idx_d = '0;
                last_d = sel;
                id_d = sel;
                state_d = RUN;
            end
            RUN: begin
                sum_d[idx_q*CHUNK_W +: CHUNK_W] = cs;
                carry_d = cc;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'(CHUNKS-1)) begin
                    cout_d = cc;
                    idx_d = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= IDW'(NREQ-1);
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            id_q <= id_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            idx_q <= idx_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_id = id_q;
    assign rsp_sum = sum_q;
    assign rsp_cout = cout_q;
endmodule

// File: tb/tb_adder6_chunk_sched.sv
// tb_adder6_chunk_sched: scoreboard bench for a 4-chunk two-requester instance and a 1-chunk sweep instance
module tb_adder6_chunk_sched;
    typedef struct packed {
        logic [0:0]  id;
        logic [23:0] sum;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] rv4, rr4, rc4, rv1, rr1, rc1;
    logic [47:0] ra4, rb4;
    logic [11:0] ra1, rb1;
    logic rspv4, rspr4, co4, rspv1, rspr1, co1;
    logic [0:0] id4, id1;
    logic [23:0] sum4;
    logic [5:0] sum1;
    exp_t q4[$], q1[$];
    int acc4[$];
    int n_vec = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    adder6_chunk_sched #(.NREQ(2), .CHUNKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4), .req_a(ra4), .req_b(rb4),
        .req_cin(rc4), .rsp_valid(rspv4), .rsp_ready(rspr4), .rsp_id(id4), .rsp_sum(sum4), .rsp_cout(co4)
    );
    adder6_chunk_sched #(.NREQ(2), .CHUNKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_a(ra1), .req_b(rb1),
        .req_cin(rc1), .rsp_valid(rspv1), .rsp_ready(rspr1), .rsp_id(id1), .rsp_sum(sum1), .rsp_cout(co1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) if (rv4[i] && rr4[i]) acc4.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rspv4 && rspr4) begin
            if (q4.size() == 0) chk("rsp4_unexpected", 32'(sum4), 32'hFFFF_FFFF);
            else begin
                e = q4.pop_front();
                chk("rsp4_id", 32'(id4), 32'(e.id));
                chk("rsp4_sum", 32'(sum4), 32'(e.sum));
                chk("rsp4_cout", 32'(co4), 32'(e.cout));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rspv1 && rspr1) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 32'(sum1), 32'hFFFF_FFFF);
            else begin
                e = q1.pop_front();
                chk("rsp1_id", 32'(id1), 32'(e.id));
                chk("rsp1_sum", 32'(sum1), 32'(e.sum));
                chk("rsp1_cout", 32'(co1), 32'(e.cout));
            end
        end
    end

    task automatic issue4(input int r, input logic [23:0] a, input logic [23:0] b, input logic cin);
        ra4[r*24 +: 24] = a;
        rb4[r*24 +: 24] = b;
        rc4[r] = cin;
        rv4[r] = 1'b1;
        #1;
    endtask

    task automatic wait_acc(input bit d);
        int k = 0;
        while (((d ? (rv1 & rr1) : (rv4 & rr4)) == 2'b00) && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(d ? "accept1_seen" : "accept4_seen", 32'(k < 50), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input bit d, input int lat);
        int n = 0;
        while (!(d ? rspv1 : rspv4) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(d ? "latency1" : "latency4", 32'(n), 32'(lat));
    endtask

    task automatic drain4();
        int k = 0;
        while (q4.size() != 0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain4", 32'(q4.size()), 32'd0);
    endtask

    initial begin
        int base, n0, hs, k;
        rst = 1'b1;
        rv4 = 2'b11; rv1 = 2'b11; rc4 = '0; rc1 = '0;
        ra4 = '0; rb4 = '0; ra1 = '0; rb1 = '0;
        rspr4 = 1'b1; rspr1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid4", 32'(rspv4), 0);
        chk("rst_sum4", 32'(sum4), 0);
        chk("rst_cout4", 32'(co4), 0);
        chk("rst_id4", 32'(id4), 0);
        chk("rst_ready4", 32'(rr4), 0);
        chk("rst_ready1", 32'(rr1), 0);
        chk("rst_valid1", 32'(rspv1), 0);
        rst = 1'b0; rv4 = '0; rv1 = '0;
        @(posedge clk);
        #1;

        q4.push_back('{1'b0, 24'h000040, 1'b0});
        issue4(0, 24'h00003F, 24'h000001, 1'b0);
        chk("ready_req0", 32'(rr4), 32'b01);
        wait_acc(0);
        rv4 = '0;
        wait_rsp(0, 4);
        @(posedge clk);
        #1;

        q4.push_back('{1'b1, 24'h000000, 1'b1});
        issue4(1, 24'hFFFFFF, 24'h000000, 1'b1);
        chk("ready_req1", 32'(rr4), 32'b10);
        wait_acc(0);
        rv4 = '0;
        wait_rsp(0, 4);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            q4.push_back(i % 2 == 0 ? '{1'b0, 24'h777777, 1'b0} : '{1'b1, 24'h000002, 1'b1});
        base = acc4.size();
        issue4(0, 24'h123456, 24'h654321, 1'b0);
        issue4(1, 24'h800000, 24'h800001, 1'b1);
        k = 0;
        while (acc4.size() < base + 4 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        rv4 = '0;
        chk("alt_accepts", 32'(acc4.size() - base), 4);
        for (int i = 1; i < 4; i++)
            if (base + i < acc4.size()) chk("alt_interval", 32'(acc4[base+i] - acc4[base+i-1]), 6);
        drain4();

        rspr4 = 1'b0;
        q4.push_back('{1'b0, 24'h001000, 1'b0});
        issue4(0, 24'h000FFF, 24'h000001, 1'b0);
        wait_acc(0);
        rv4 = '0;
        q4.push_back('{1'b1, 24'hBE0245, 1'b0});
        issue4(1, 24'hABCDEF, 24'h123456, 1'b0);
        wait_rsp(0, 4);
        n0 = acc4.size();
        repeat (3) begin
            chk("stall_valid", 32'(rspv4), 1);
            chk("stall_sum", 32'(sum4), 32'h001000);
            chk("stall_id", 32'(id4), 0);
            chk("stall_cout", 32'(co4), 0);
            chk("stall_ready", 32'(rr4), 0);
            @(posedge clk);
            #1;
        end
        rspr4 = 1'b1;
        #1;
        chk("hs_ready", 32'(rr4), 0);
        chk("stall_no_accept", 32'(acc4.size()), 32'(n0));
        hs = cyc;
        @(posedge clk);
        #1;
        chk("post_hs_ready", 32'(rr4), 32'b10);
        wait_acc(0);
        rv4 = '0;
        chk("accept_after_hs", 32'(acc4[$] - hs), 1);
        wait_rsp(0, 4);
        @(posedge clk);
        #1;

        issue4(1, 24'h111111, 24'h222222, 1'b0);
        wait_acc(0);
        rv4 = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue4(0, 24'hFFFFC0, 24'h000040, 1'b0);
        issue4(1, 24'h333333, 24'h000001, 1'b0);
        chk("rst_mid_ready", 32'(rr4), 0);
        n0 = acc4.size();
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(rspv4), 0);
        chk("rst_mid_sum", 32'(sum4), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(rr4), 32'b01);
        q4.push_back('{1'b0, 24'h000000, 1'b1});
        wait_acc(0);
        rv4 = '0;
        chk("post_rst_accepts", 32'(acc4.size()), 32'(n0 + 1));
        wait_rsp(0, 4);
        @(posedge clk);
        #1;
        drain4();
        repeat (8) @(posedge clk);
        #1;
        chk("no_stray_valid", 32'(rspv4), 0);

        for (int v = 0; v < 8192; v++) begin
            logic [5:0] a, b;
            logic ci, r;
            logic [6:0] s;
            a = v[12:7];
            b = v[6:1];
            ci = v[0];
            r = v[4] ^ v[9];
            s = {1'b0, a} + {1'b0, b} + {6'b0, ci};
            ra1 = {a, a};
            rb1 = {b, b};
            rc1 = {ci, ci};
            rv1 = r ? 2'b10 : 2'b01;
            q1.push_back('{r, 24'(s[5:0]), s[6]});
            #1;
            wait_acc(1);
            rv1 = '0;
            wait_rsp(1, 1);
            @(posedge clk);
            #1;
        end
        chk("drain1", 32'(q1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder6_chunk_sched.md
# adder6_chunk_sched

Multi-cycle scheduler that shares one combinational 6-bit ripple adder (6-bit A, 6-bit B, carry-in → 6-bit sum, carry-out) among several requesters. Each request is a wide addition of `6*CHUNKS` bits, executed one 6-bit chunk per cycle, LSB chunk first, with the carry held in a register between chunks. A round-robin arbiter picks the requester. The result is returned on a single response channel tagged with the requester id. It sits between the benchmark adder datapath and the blocks needing wide arithmetic, replacing per-requester wide adders.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; legal 2..8.
- `CHUNKS`, 4: chunks per operand; legal 1..8. Operand width `W = 6*CHUNKS`.
- `IDW`, `$clog2(NREQ)`: id width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*W  operand A, requester i at bits `[i*W +: W]`.
- `req_b`  in  NREQ*W  operand B, same packing.
- `req_cin`  in  NREQ  carry-in per requester.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  index of the requester that issued the result.
- `rsp_sum`  out  W  A + B + cin, low W bits.
- `rsp_cout`  out  1  carry out of the top chunk.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - Arbiter selects the first `req_valid[i]` searching from `(last+1) mod NREQ` upward with wrap.
  - `req_ready[sel]=1` combinationally; all other bits are 0.
  - On valid&ready, latch A, B and id, set `carry=req_cin[sel]`, `idx=0`, `last=sel`, then go to RUN.
  - If no request is valid, stay in IDLE with `last` unchanged.
- **RUN:**
  - Adder inputs are `A[idx*6 +: 6]`, `B[idx*6 +: 6]` and `carry`.
  - Each cycle, store the 6-bit sum into `rsp_sum[idx*6 +: 6]`, set `carry=cout`, and `idx++`.
  - When `idx==CHUNKS-1`, the final carry goes to `rsp_cout` and the FSM goes to DONE.
  - `req_ready` is all 0.
- **DONE:**
  - `rsp_valid=1`; `rsp_sum`, `rsp_cout` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE. `req_ready` stays 0 in DONE, including the handshake cycle.
- Requesters hold `req_valid` and their data stable until accepted. A request may be withdrawn before acceptance; the scheduler does not depend on it staying asserted.
- Arithmetic is unsigned modulo 2^W. `{rsp_cout, rsp_sum}` equals `A + B + cin` exactly (W+1 bits).
- CHUNKS=1: RUN lasts one cycle; the result equals one pass of the 6-bit adder.

## Timing
- Reset values: `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, FSM=IDLE, `last=NREQ-1` (requester 0 has first priority), `carry=0`, `idx=0`. `req_ready` is forced to 0 while `rst=1`.
- Request accepted in cycle c0. Chunks are computed in cycles c1..cCHUNKS. `rsp_valid` rises in cycle c(CHUNKS+1).
- If `rsp_ready=1` in c(CHUNKS+1): FSM is IDLE in c(CHUNKS+2), and the next accept is possible in that cycle. Minimum issue interval is CHUNKS+2 cycles.
- `req_valid` → `req_ready` is a combinational path. All other outputs are registered.
- Reset asserted in any state (including mid-RUN or DONE with `rsp_ready=0`):
  - The in-flight operation is dropped and no response is issued.
  - The cycle after reset deasserts, the FSM is in IDLE with the arbiter pointer restored.
- Simultaneous valids: exactly one grant per IDLE cycle. Under continuous demand, no requester waits more than NREQ-1 operations.

## Structure
- Shared package `adder6_pkg`:
  - `CHUNK_W=6`.
  - State enum `sched_state_t` {IDLE, RUN, DONE}.
  - Function `rr_pick(valid, last)` returning the granted index and a found flag.
- One sub-module, `adder6_core`: the purely combinational 6-bit adder (a[5:0], b[5:0], cin → sum[5:0], cout). It is instantiated exactly once; no other adder logic exists in the block.
- Chunk muxing, carry register, result register and arbiter live in the top level.

## Test plan
- NREQ=2, CHUNKS=4. Req0: A=24'h00003F, B=24'h000001, cin=0 → in c5, `rsp_sum=24'h000040`, `rsp_cout=0`, `rsp_id=0` (carry crosses chunk boundary).
- Req1: A=24'hFFFFFF, B=0, cin=1 → `rsp_sum=24'h000000`, `rsp_cout=1`, `rsp_id=1`.
- Both requesters valid continuously, `rsp_ready=1` → accepts alternate 0,1,0,1 every 6 cycles. `rsp_id` matches, and each sum equals the golden model.
- Hold `rsp_ready=0` for 3 cycles after `rsp_valid` → outputs stable, `req_ready=0` throughout, no second accept. Accept occurs the cycle after the handshake.
- Assert `rst` in c2 of an operation → no `rsp_valid` ever for that operation. With both valid afterwards, the first grant goes to req0.
- CHUNKS=1: exhaustive sweep of all 2^13 (A, B, cin) → `{rsp_cout, rsp_sum}=A+B+cin` in every case, latency 2 cycles.
